wdt_multi_window: RTL and testbench

//  Parametrised N-channel watchdog timer with shared prescaler and per-channel windowed kick.

---
 rtl/wdt_multi_window.sv | 134 +++++++++++++
 tb/tb_wdt_multi_window.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/wdt_multi_window.sv
// N-channel windowed watchdog timer. Channels share one prescaler and otherwise run independently;
// a channel times out on count expiry or on a kick that arrives while the count is above its window.
`timescale 1ns/1ps
module wdt_multi_window #(
    parameter int N_CH  = 2,
    parameter int CNT_W = 32,
    parameter int PRE_W = 8
) (
    input  logic                    clk2,
    input  logic                    rstn2,
    input  logic [N_CH-1:0]         wden,
    input  logic [N_CH-1:0]         wdlive,
    input  logic [N_CH*CNT_W-1:0]   wtocnt,
    input  logic [N_CH*CNT_W-1:0]   wwin,
    input  logic [PRE_W-1:0]        prescale,
    output logic [N_CH-1:0]         wto,
    output logic                    wto_any,
    output logic [N_CH-1:0]         wto_early
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_EXP  = 2'd2;

    logic [PRE_W-1:0]            pre_q, pre_d;
    logic                        tick_s;
    logic [N_CH-1:0][1:0]        state_q, state_d;
    logic [N_CH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_CH-1:0]             early_q, early_d;
    logic [N_CH-1:0]             wto_q, wto_d;
    logic [N_CH-1:0]             wto_early_q, wto_early_d;
    logic                        wto_any_q, wto_any_d;

    // Shared prescaler: parked at zero while no channel is enabled.
    always_comb begin
        pre_d  = pre_q;
        tick_s = 1'b0;
        if (!(|wden)) begin
            pre_d = {PRE_W{1'b0}};
        end else if (pre_q == prescale) begin
            pre_d  = {PRE_W{1'b0}};
            tick_s = 1'b1;
        end else begin
            pre_d = pre_q + {{(PRE_W-1){1'b0}}, 1'b1};
        end
    end

    // Per-channel FSM; the zero check precedes the decrement so the counter never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        early_d = early_q;
        for (int i = 0; i < N_CH; i++) begin
            case (state_q[i])
                ST_IDLE: begin
                    cnt_d[i]   = wtocnt[i*CNT_W +: CNT_W];
                    early_d[i] = 1'b0;
                    if (wden[i]) begin
                        state_d[i] = ST_RUN;
                    end else begin
                        state_d[i] = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (!wden[i]) begin
                        state_d[i] = ST_IDLE;
                    end else if (wdlive[i] && (wwin[i*CNT_W +: CNT_W] != {CNT_W{1'b0}})
                                 && (cnt_q[i] > wwin[i*CNT_W +: CNT_W])) begin
                        state_d[i] = ST_EXP;
                        early_d[i] = 1'b1;
                    end else if (wdlive[i]) begin
                        cnt_d[i] = wtocnt[i*CNT_W +: CNT_W];
                    end else if (tick_s && (cnt_q[i] == {CNT_W{1'b0}})) begin
                        state_d[i] = ST_EXP;
                        early_d[i] = 1'b0;
                    end else if (tick_s) begin
                        cnt_d[i] = cnt_q[i] - {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        cnt_d[i] = cnt_q[i];
                    end
                end
                ST_EXP: begin
                    if (!wden[i]) begin
                        state_d[i] = ST_IDLE;
                        early_d[i] = 1'b0;
                    end else begin
                        state_d[i] = ST_EXP;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    cnt_d[i]   = {CNT_W{1'b0}};
                    early_d[i] = 1'b0;
                end
            endcase
        end
    end

    // Output terms: timeout is only shown while the channel is still enabled.
    always_comb begin
        wto_d = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            wto_d[i] = (state_q[i] == ST_EXP) & wden[i];
        end
        wto_early_d = early_q & wto_d;
        wto_any_d   = |wto_d;
    end

    // State and output registers.
    always_ff @(posedge clk2 or negedge rstn2) begin
        if (!rstn2) begin
            pre_q       <= {PRE_W{1'b0}};
            state_q     <= {N_CH{ST_IDLE}};
            cnt_q       <= {(N_CH*CNT_W){1'b0}};
            early_q     <= {N_CH{1'b0}};
            wto_q       <= {N_CH{1'b0}};
            wto_early_q <= {N_CH{1'b0}};
            wto_any_q   <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            early_q     <= early_d;
            wto_q       <= wto_d;
            wto_early_q <= wto_early_d;
            wto_any_q   <= wto_any_d;
        end
    end

    assign wto       = wto_q;
    assign wto_early = wto_early_q;
    assign wto_any   = wto_any_q;

endmodule

// File: tb/tb_wdt_multi_window.sv
// Directed bench for wdt_multi_window: expectations queued as stimulus is applied, compared
// after the DUT has had the cycles it needs. A narrow build (CNT_W=16, PRE_W=4) runs alongside.
`timescale 1ns/1ps
module tb_wdt_multi_window;

    logic        clk2 = 1'b0;
    logic        rstn2;
    logic [1:0]  wden, wdlive, wto, wto_early;
    logic [63:0] wtocnt, wwin;
    logic [7:0]  prescale;
    logic        wto_any;

    logic [1:0]  wden16, wdlive16, wto16, wto_early16;
    logic [31:0] wtocnt16, wwin16;
    logic [3:0]  prescale16;
    logic        wto_any16;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [1:0] wto;
        logic [1:0] early;
        logic       any;
    } exp_t;
    exp_t sb[$];

    wdt_multi_window #(.N_CH(2), .CNT_W(32), .PRE_W(8)) dut (
        .clk2(clk2), .rstn2(rstn2), .wden(wden), .wdlive(wdlive), .wtocnt(wtocnt),
        .wwin(wwin), .prescale(prescale), .wto(wto), .wto_any(wto_any), .wto_early(wto_early)
    );

    wdt_multi_window #(.N_CH(2), .CNT_W(16), .PRE_W(4)) dut16 (
        .clk2(clk2), .rstn2(rstn2), .wden(wden16), .wdlive(wdlive16), .wtocnt(wtocnt16),
        .wwin(wwin16), .prescale(prescale16), .wto(wto16), .wto_any(wto_any16),
        .wto_early(wto_early16)
    );

    always #5 clk2 = ~clk2;

    task automatic step(input int n);
        repeat (n) @(posedge clk2);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic [1:0] w, input logic [1:0] e,
                            input logic a);
        exp_t x;
        x.tag = tag; x.wto = w; x.early = e; x.any = a;
        sb.push_back(x);
    endtask

    task automatic pop_check();
        exp_t x;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL sb_empty: no expectation queued");
        end else begin
            x = sb.pop_front();
            assert ({wto, wto_early, wto_any} === {x.wto, x.early, x.any}) else begin
                failures++;
                $error("FAIL %s: wto=%b early=%b any=%b expected wto=%b early=%b any=%b",
                       x.tag, wto, wto_early, wto_any, x.wto, x.early, x.any);
            end
        end
    endtask

    // Queue an expectation, advance n cycles, then compare.
    task automatic run_expect(input int n, input string tag, input logic [1:0] w,
                              input logic [1:0] e, input logic a);
        push_exp(tag, w, e, a);
        step(n);
        pop_check();
    endtask

    task automatic wait_wto(input bit narrow, input int bound, output int c);
        c = 0;
        while (c < bound && !(narrow ? wto16[0] : wto[0])) begin
            step(1);
            c++;
        end
    endtask

    task automatic chk_range(input string tag, input int c, input int lo, input int hi);
        checks++;
        assert (c >= lo && c <= hi) else begin
            failures++;
            $error("FAIL %s: cycles=%0d expected %0d..%0d", tag, c, lo, hi);
        end
    endtask

    initial begin
        int c;
        rstn2 = 1'b0; wden = 2'b00; wdlive = 2'b00; wtocnt = 64'd0; wwin = 64'd0;
        prescale = 8'd0;
        wden16 = 2'b00; wdlive16 = 2'b00; wtocnt16 = 32'd0; wwin16 = 32'd0; prescale16 = 4'd0;
        step(2);
        run_expect(0, "reset", 2'b00, 2'b00, 1'b0);
        rstn2 = 1'b1;
        step(1);

        // Plain expiry, prescale 0, W=5: wto after edge 7 counting the first RUN edge as 0.
        wtocnt[31:0] = 32'd5; wden = 2'b01;
        wait_wto(1'b0, 50, c);
        chk_range("expiry_p0", c, 8, 8);
        run_expect(0, "expiry_p0_out", 2'b01, 2'b00, 1'b1);
        wden = 2'b00;
        run_expect(1, "expiry_wden_off", 2'b00, 2'b00, 1'b0);
        step(1);

        // Prescale 3, W=2: (2+1)*4+1 cycles after the first RUN edge, +/-1 for prescaler phase.
        prescale = 8'd3; wtocnt[31:0] = 32'd2; wden = 2'b01;
        wait_wto(1'b0, 60, c);
        chk_range("expiry_p3", c, 13, 15);
        wden = 2'b00;
        step(2);

        // Kick every 8 cycles keeps the channel alive for 200 cycles.
        wden = 2'b01;
        for (int k = 0; k < 25; k++) begin
            push_exp("kick_alive", 2'b00, 2'b00, 1'b0);
            step(7);
            wdlive = 2'b01;
            step(1);
            wdlive = 2'b00;
            pop_check();
        end
        wden = 2'b00;
        step(2);

        // Window: W=10, window=4. Kick at cnt=7 is early.
        prescale = 8'd0; wtocnt[31:0] = 32'd10; wwin[31:0] = 32'd4; wden = 2'b01;
        step(4);
        wdlive = 2'b01;
        step(1);
        wdlive = 2'b00;
        run_expect(1, "early_kick", 2'b01, 2'b01, 1'b1);
        wden = 2'b00;
        run_expect(1, "early_cleared", 2'b00, 2'b00, 1'b0);
        step(1);
        // Kick at cnt=3 reloads; expiry then follows 12 cycles after the kick.
        wden = 2'b01;
        step(8);
        wdlive = 2'b01;
        step(1);
        wdlive = 2'b00;
        run_expect(11, "valid_kick_hold", 2'b00, 2'b00, 1'b0);
        run_expect(1, "valid_kick_expiry", 2'b01, 2'b00, 1'b1);
        wden = 2'b00; wwin[31:0] = 32'd0;
        step(2);

        // Kick coincident with tick at cnt=0 reloads instead of expiring.
        wtocnt[31:0] = 32'd5; wden = 2'b01;
        step(6);
        wdlive = 2'b01;
        step(1);
        wdlive = 2'b00;
        run_expect(1, "kick_at_zero", 2'b00, 2'b00, 1'b0);
        run_expect(5, "kick_at_zero_late", 2'b00, 2'b00, 1'b0);
        run_expect(1, "kick_at_zero_exp", 2'b01, 2'b00, 1'b1);
        wdlive = 2'b01;
        run_expect(1, "exp_ignores_kick", 2'b01, 2'b00, 1'b1);
        wdlive = 2'b00; wden = 2'b00;
        run_expect(1, "exp_wden_low", 2'b00, 2'b00, 1'b0);
        wden = 2'b01;
        run_expect(2, "back_to_idle", 2'b00, 2'b00, 1'b0);
        wden = 2'b00;
        step(2);

        // Independent channels: W0=3 expires at edge 5, W1=8 at edge 10.
        wtocnt = {32'd8, 32'd3}; wden = 2'b11;
        run_expect(5, "indep_none", 2'b00, 2'b00, 1'b0);
        run_expect(1, "indep_ch0", 2'b01, 2'b00, 1'b1);
        run_expect(4, "indep_ch0_only", 2'b01, 2'b00, 1'b1);
        run_expect(1, "indep_both", 2'b11, 2'b00, 1'b1);
        rstn2 = 1'b0;
        #1;
        run_expect(0, "async_reset", 2'b00, 2'b00, 1'b0);
        step(1);
        wden = 2'b00; rstn2 = 1'b1;
        step(2);

        // W=0 times out on the first tick after enable (prescale 2: tick on edge 2).
        wtocnt = 64'd0; prescale = 8'd2; wden = 2'b01;
        run_expect(3, "w0_before_tick", 2'b00, 2'b00, 1'b0);
        run_expect(1, "w0_expiry", 2'b01, 2'b00, 1'b1);
        wden = 2'b00;
        step(2);

        // Narrow build: W=5, prescale 1 -> (5+1)*2+1 cycles, +/-1 for prescaler phase.
        prescale16 = 4'd1; wtocnt16[15:0] = 16'd5; wden16 = 2'b01;
        wait_wto(1'b1, 60, c);
        chk_range("narrow_expiry", c, 13, 15);
        checks++;
        assert ({wto16, wto_early16, wto_any16} === {2'b01, 2'b00, 1'b1}) else begin
            failures++;
            $error("FAIL narrow_out: wto=%b early=%b any=%b expected wto=01 early=00 any=1",
                   wto16, wto_early16, wto_any16);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
